// File: rtl/cci_mpf_event_counter_bank.sv
// Parametrised MPF event-counter bank: per-event accumulate (wrap/saturate), sticky overflow, fixed-latency indexed reads.
// Optional coherent snapshot shadow enabled by defining CCI_MPF_EVT_SNAPSHOT_EN.

module cci_mpf_event_counter_lane #(
    parameter int CNT_WIDTH  = 48,
    parameter int INCR_WIDTH = 1,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [INCR_WIDTH-1:0] incr,
    input  logic                  clr,
    output logic [CNT_WIDTH-1:0]  cnt,
    output logic                  ovf
);
    logic [CNT_WIDTH:0] sum;

    assign sum = {1'b0, cnt} + (CNT_WIDTH+1)'(incr);

    // A clear loads the increment landing on the same edge so no event is dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= CNT_WIDTH'(incr);
            ovf <= 1'b0;
        end else if (sum[CNT_WIDTH]) begin
            cnt <= (SATURATE != 0) ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
            ovf <= 1'b1;
        end else begin
            cnt <= sum[CNT_WIDTH-1:0];
        end
    end
endmodule

module cci_mpf_event_counter_bank #(
    parameter int N_EVENTS   = 8,
    parameter int CNT_WIDTH  = 48,
    parameter int INCR_WIDTH = 1,
    parameter int SATURATE   = 0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [N_EVENTS*INCR_WIDTH-1:0] evt_incr,
    input  logic                           clr_all,
    input  logic                           clr_en,
    input  logic [5:0]                     clr_idx,
    input  logic                           rd_req,
    input  logic [5:0]                     rd_idx,
    output logic                           rd_rsp_valid,
    output logic [63:0]                    rd_rsp_data,
    output logic                           rd_rsp_ovf,
    output logic                           rd_rsp_err,
    input  logic                           snap_req
);
    localparam int STAGES = 1;

    typedef struct packed {
        logic [63:0] data;
        logic        ovf;
        logic        err;
    } rsp_t;

    logic [N_EVENTS-1:0][INCR_WIDTH-1:0] incr_q;
    logic [N_EVENTS-1:0][CNT_WIDTH-1:0]  cnt;
    logic [N_EVENTS-1:0]                 ovf;
    logic [N_EVENTS-1:0][CNT_WIDTH-1:0]  src_cnt;
    logic [N_EVENTS-1:0]                 src_ovf;
    logic [STAGES:0]                     vld_pipe;
    rsp_t                                rsp_sel, rsp_q, rsp_out;

    always_ff @(posedge clk) begin
        if (!reset_n) incr_q <= '0;
        else          incr_q <= evt_incr;
    end

    for (genvar i = 0; i < N_EVENTS; i++) begin : g_lane
        logic clr_hit;
        assign clr_hit = clr_all | (clr_en & (clr_idx == 6'(i)));

        cci_mpf_event_counter_lane #(
            .CNT_WIDTH (CNT_WIDTH),
            .INCR_WIDTH(INCR_WIDTH),
            .SATURATE  (SATURATE)
        ) u_lane (
            .clk    (clk),
            .reset_n(reset_n),
            .incr   (incr_q[i]),
            .clr    (clr_hit),
            .cnt    (cnt[i]),
            .ovf    (ovf[i])
        );
    end

`ifdef CCI_MPF_EVT_SNAPSHOT_EN
    logic [N_EVENTS-1:0][CNT_WIDTH-1:0] shd_cnt;
    logic [N_EVENTS-1:0]                shd_ovf;

    // Reads sampled on the snapshot edge still see the previous shadow.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shd_cnt <= '0;
            shd_ovf <= '0;
        end else if (snap_req) begin
            shd_cnt <= cnt;
            shd_ovf <= ovf;
        end
    end

    assign src_cnt = shd_cnt;
    assign src_ovf = shd_ovf;
`else
    logic snap_unused;
    assign snap_unused = snap_req;
    assign src_cnt     = cnt;
    assign src_ovf     = ovf;
`endif

    always_comb begin
        rsp_sel     = '0;
        rsp_sel.err = 1'b1;
        for (int i = 0; i < N_EVENTS; i++) begin
            if (rd_idx == 6'(i)) begin
                rsp_sel.data = 64'(src_cnt[i]);
                rsp_sel.ovf  = src_ovf[i];
                rsp_sel.err  = 1'b0;
            end
        end
    end

    // Response fields are forced to zero whenever the matching valid bit is low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            rsp_q    <= '0;
            rsp_out  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], rd_req};
            rsp_q    <= rd_req ? rsp_sel : '0;
            rsp_out  <= vld_pipe[0] ? rsp_q : '0;
        end
    end

    assign rd_rsp_valid = vld_pipe[STAGES];
    assign rd_rsp_data  = rsp_out.data;
    assign rd_rsp_ovf   = rsp_out.ovf;
    assign rd_rsp_err   = rsp_out.err;
endmodule

// File: tb/tb_cci_mpf_event_counter_bank.sv
// Directed, table-driven bench for cci_mpf_event_counter_bank: a wrap-mode 8x8-bit bank (2-bit incr)
// and a saturating 4x8-bit bank (1-bit incr).
module tb_cci_mpf_event_counter_bank;
    localparam int NA = 8, CWA = 8, IWA = 2;
    localparam int NB = 4, CWB = 8, IWB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic [NA*IWA-1:0] a_evt;
    logic              a_clr_all, a_clr_en, a_rd_req, a_snap;
    logic [5:0]        a_clr_idx, a_rd_idx;
    logic              a_vld, a_ovf, a_err;
    logic [63:0]       a_data;

    logic [NB*IWB-1:0] b_evt;
    logic              b_clr_all, b_clr_en, b_rd_req, b_snap;
    logic [5:0]        b_clr_idx, b_rd_idx;
    logic              b_vld, b_ovf, b_err;
    logic [63:0]       b_data;

    cci_mpf_event_counter_bank #(.N_EVENTS(NA), .CNT_WIDTH(CWA), .INCR_WIDTH(IWA), .SATURATE(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .evt_incr(a_evt), .clr_all(a_clr_all), .clr_en(a_clr_en),
        .clr_idx(a_clr_idx), .rd_req(a_rd_req), .rd_idx(a_rd_idx), .rd_rsp_valid(a_vld),
        .rd_rsp_data(a_data), .rd_rsp_ovf(a_ovf), .rd_rsp_err(a_err), .snap_req(a_snap)
    );

    cci_mpf_event_counter_bank #(.N_EVENTS(NB), .CNT_WIDTH(CWB), .INCR_WIDTH(IWB), .SATURATE(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .evt_incr(b_evt), .clr_all(b_clr_all), .clr_en(b_clr_en),
        .clr_idx(b_clr_idx), .rd_req(b_rd_req), .rd_idx(b_rd_idx), .rd_rsp_valid(b_vld),
        .rd_rsp_data(b_data), .rd_rsp_ovf(b_ovf), .rd_rsp_err(b_err), .snap_req(b_snap)
    );

    typedef struct {
        logic [5:0]  idx;
        logic [63:0] data;
        logic        ovf;
        logic        err;
    } vec_t;

    vec_t tbl [7];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_a(input int slot, input logic [1:0] v);
        a_evt[slot*IWA +: IWA] = v;
    endtask

    task automatic inc_a(input int slot, input logic [1:0] v, input int n);
        set_a(slot, v);
        tick(n);
        a_evt = '0;
        tick(2);
    endtask

    task automatic rd_chk(input bit sel, input logic [5:0] idx, input bit do_snap,
                          input logic [63:0] ed, input logic eo, input logic ee, input string nm);
        if (do_snap) begin
            if (sel) b_snap = 1'b1; else a_snap = 1'b1;
            tick(1);
            a_snap = 1'b0;
            b_snap = 1'b0;
        end
        if (sel) begin b_rd_req = 1'b1; b_rd_idx = idx; end
        else     begin a_rd_req = 1'b1; a_rd_idx = idx; end
        tick(1);
        a_rd_req = 1'b0;
        b_rd_req = 1'b0;
        chk({nm, ".early"}, sel ? b_vld : a_vld, 0);
        tick(1);
        chk({nm, ".valid"}, sel ? b_vld : a_vld, 1);
        chk({nm, ".data"},  sel ? b_data : a_data, ed);
        chk({nm, ".ovf"},   sel ? b_ovf : a_ovf, 64'(eo));
        chk({nm, ".err"},   sel ? b_err : a_err, 64'(ee));
        tick(1);
        chk({nm, ".drop"},  sel ? b_vld : a_vld, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{6'd0,  64'd10, 1'b0, 1'b0};
        tbl[1] = '{6'd1,  64'd10, 1'b0, 1'b0};
        tbl[2] = '{6'd7,  64'd9,  1'b0, 1'b0};
        tbl[3] = '{6'd9,  64'd0,  1'b0, 1'b1};
        tbl[4] = '{6'd3,  64'd2,  1'b0, 1'b0};
        tbl[5] = '{6'd5,  64'd0,  1'b0, 1'b0};
        tbl[6] = '{6'd63, 64'd0,  1'b0, 1'b1};

        reset_n = 1'b0;
        a_evt = '0; a_clr_all = 0; a_clr_en = 0; a_clr_idx = 0; a_rd_req = 0; a_rd_idx = 0; a_snap = 0;
        b_evt = '0; b_clr_all = 0; b_clr_en = 0; b_clr_idx = 0; b_rd_req = 0; b_rd_idx = 0; b_snap = 0;
        tick(3);
        chk("rst.valid", a_vld, 0);
        chk("rst.data",  a_data, 0);
        chk("rst.ovf",   a_ovf, 0);
        chk("rst.err",   a_err, 0);
        chk("rst.b_valid", b_vld, 0);
        reset_n = 1'b1;
        tick(1);

        // Ten single events on counter 0.
        inc_a(0, 2'd1, 10);
        rd_chk(0, 6'd0, 1, 64'd10, 0, 0, "cnt10");

        // Wrap: 84*3 + 2 = 254, then +3 wraps to 1 with overflow.
        inc_a(3, 2'd3, 84);
        inc_a(3, 2'd2, 1);
        rd_chk(0, 6'd3, 1, 64'd254, 0, 0, "pre_wrap");
        inc_a(3, 2'd3, 1);
        rd_chk(0, 6'd3, 1, 64'd1, 1, 0, "wrap");

        // Clear of counter 3 lands on the same edge as a registered increment of 2.
        set_a(3, 2'd2);
        tick(1);
        a_evt = '0;
        a_clr_en = 1'b1; a_clr_idx = 6'd3;
        tick(1);
        a_clr_en = 1'b0;
        tick(2);
        rd_chk(0, 6'd3, 1, 64'd2, 0, 0, "clr_coinc");

        // Out-of-range single clear is ignored.
        a_clr_en = 1'b1; a_clr_idx = 6'd9;
        tick(1);
        a_clr_en = 1'b0;
        tick(1);
        rd_chk(0, 6'd0, 1, 64'd10, 0, 0, "clr_oob");

        // Back-to-back reads from the table.
        inc_a(1, 2'd2, 5);
        inc_a(7, 2'd3, 3);
        a_snap = 1'b1;
        tick(1);
        a_snap = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            if (c < 7) begin a_rd_req = 1'b1; a_rd_idx = tbl[c].idx; end
            else a_rd_req = 1'b0;
            tick(1);
            if (c == 0) chk("tbl.lat", a_vld, 0);
            else begin
                chk($sformatf("tbl%0d.valid", c-1), a_vld, 1);
                chk($sformatf("tbl%0d.data", c-1),  a_data, tbl[c-1].data);
                chk($sformatf("tbl%0d.ovf", c-1),   a_ovf, 64'(tbl[c-1].ovf));
                chk($sformatf("tbl%0d.err", c-1),   a_err, 64'(tbl[c-1].err));
            end
        end
        tick(1);
        chk("tbl.drop", a_vld, 0);

        // Read and clear of the same counter on one edge returns the pre-clear value.
        a_snap = 1'b1;
        tick(1);
        a_snap = 1'b0;
        a_rd_req = 1'b1; a_rd_idx = 6'd0;
        a_clr_en = 1'b1; a_clr_idx = 6'd0;
        tick(1);
        a_rd_req = 1'b0; a_clr_en = 1'b0;
        tick(1);
        chk("rdclr.valid", a_vld, 1);
        chk("rdclr.data",  a_data, 10);
        tick(1);
        rd_chk(0, 6'd0, 1, 64'd0, 0, 0, "post_clr");

        // clr_all with a coincident increment on counter 0.
        set_a(0, 2'd1);
        tick(1);
        a_evt = '0;
        a_clr_all = 1'b1;
        tick(1);
        a_clr_all = 1'b0;
        tick(1);
        rd_chk(0, 6'd0, 1, 64'd1, 0, 0, "clrall.c0");
        rd_chk(0, 6'd7, 1, 64'd0, 0, 0, "clrall.c7");

        // Reset one cycle after a read request discards the response.
        a_rd_req = 1'b1; a_rd_idx = 6'd0;
        tick(1);
        a_rd_req = 1'b0;
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        chk("rstrd.v1", a_vld, 0);
        tick(1);
        chk("rstrd.v2", a_vld, 0);
        tick(1);
        chk("rstrd.v3", a_vld, 0);
        rd_chk(0, 6'd0, 1, 64'd0, 0, 0, "rst.c0");
        rd_chk(0, 6'd1, 1, 64'd0, 0, 0, "rst.c1");

`ifdef CCI_MPF_EVT_SNAPSHOT_EN
        set_a(0, 2'd1);
        set_a(1, 2'd1);
        tick(5);
        set_a(0, 2'd0);
        tick(2);
        set_a(1, 2'd0);
        tick(2);
        a_snap = 1'b1;
        tick(1);
        a_snap = 1'b0;
        inc_a(0, 2'd1, 20);
        rd_chk(0, 6'd0, 0, 64'd5, 0, 0, "snap.c0");
        rd_chk(0, 6'd1, 0, 64'd7, 0, 0, "snap.c1");
        rd_chk(0, 6'd0, 1, 64'd25, 0, 0, "snap2.c0");
`endif

        // Saturating bank.
        b_evt[0] = 1'b1;
        tick(250);
        b_evt = '0;
        tick(2);
        rd_chk(1, 6'd0, 1, 64'd250, 0, 0, "sat250");
        b_evt[0] = 1'b1;
        tick(10);
        b_evt = '0;
        tick(2);
        rd_chk(1, 6'd0, 1, 64'd255, 1, 0, "sat");
        b_evt[0] = 1'b1;
        tick(5);
        b_evt = '0;
        tick(2);
        rd_chk(1, 6'd0, 1, 64'd255, 1, 0, "sat_hold");
        rd_chk(1, 6'd4, 1, 64'd0, 0, 1, "b_oob");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
